// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard control bundle.
// Carries the hazard-detection inputs from the pipeline and the stall/flush/status
// outputs back to it.
//   master : the pipeline side; drives the hazard inputs and receives the controls
//   slave  : hazard_stall_ctrl; receives the hazard inputs and drives the controls
// Signals:
//   ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, ifid_halt : ID-stage instruction info
//   idex_rd, idex_regwrite, idex_memread                    : EX-stage instruction info
//   ex_take_branch, imem_stall, dmem_stall                  : redirect and memory busy
//   pc_stall .. memwb_stall, ifid_flush, idex_flush          : pipeline register controls
//   halted, err                                              : registered status
interface hazard_stall_ctrl_if;
  logic [2:0] ifid_rs;
  logic [2:0] ifid_rt;
  logic       ifid_rs_used;
  logic       ifid_rt_used;
  logic       ifid_halt;
  logic [2:0] idex_rd;
  logic       idex_regwrite;
  logic       idex_memread;
  logic       ex_take_branch;
  logic       imem_stall;
  logic       dmem_stall;

  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_stall;
  logic       exmem_stall;
  logic       memwb_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       halted;
  logic       err;

  modport master (
    output ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, ifid_halt,
    output idex_rd, idex_regwrite, idex_memread,
    output ex_take_branch, imem_stall, dmem_stall,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
    input  ifid_flush, idex_flush, halted, err
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, ifid_halt,
    input  idex_rd, idex_regwrite, idex_memread,
    input  ex_take_branch, imem_stall, dmem_stall,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
    output ifid_flush, idex_flush, halted, err
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 16-bit five-stage core.
// Detects load-use hazards, taken-branch redirects and instruction/data memory busy
// conditions, and sequences the HALT drain (RUN -> DRAIN -> HALTED).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_stall_ctrl_if.slave
//           inputs  - ID/EX instruction info, ex_take_branch, imem_stall, dmem_stall
//           outputs - five stalls, two flushes (combinational), halted/err (registered)
// Parameters:
//   MEM_TIMEOUT  : consecutive dmem_stall cycles that raise err (2..255)
//   DRAIN_CYCLES : cycles to drain a HALT from ID through WB (1..7)
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  localparam logic [7:0] TmoLast   = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e     state_q;
  logic [2:0] drain_cnt_q;
  logic [7:0] tmo_cnt_q;
  logic       halted_q;
  logic       err_q;

  logic load_use;
  logic halt_enter;

  logic pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic ifid_flush, idex_flush;

  assign load_use = bus.idex_memread & bus.idex_regwrite &
                    ((bus.ifid_rs_used & (bus.ifid_rs == bus.idex_rd)) |
                     (bus.ifid_rt_used & (bus.ifid_rt == bus.idex_rd)));

  // A HALT only starts draining once it is certain to advance out of ID this edge.
  assign halt_enter = bus.ifid_halt & ~bus.dmem_stall & ~bus.ex_take_branch & ~load_use;

  // Priority chain; the first matching condition wins.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst_n) begin
      // All controls quiet while in reset regardless of inputs.
    end else if (state_q == StHalted || bus.dmem_stall) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (bus.ex_take_branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == StDrain) begin
      // Stop fetching; everything behind the HALT becomes bubbles.
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in ID and push one bubble behind the load.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (bus.imem_stall) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  // Single state machine: drain sequencing, memory timeout and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      drain_cnt_q <= 3'd0;
      tmo_cnt_q   <= 8'd0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (bus.dmem_stall) begin
        if (tmo_cnt_q != 8'hFF) begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
        // Compare the pre-increment count so err lands on the MEM_TIMEOUT-th busy edge.
        if (tmo_cnt_q >= TmoLast) begin
          err_q <= 1'b1;
        end
      end else begin
        tmo_cnt_q <= 8'd0;
      end

      unique case (state_q)
        StRun: begin
          if (halt_enter) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainInit;
          end
        end
        StDrain: begin
          // A memory stall freezes the drain for that cycle.
          if (!bus.dmem_stall) begin
            if (drain_cnt_q == 3'd0) begin
              state_q  <= StHalted;
              halted_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - 3'd1;
            end
          end
        end
        StHalted: begin
          // Terminal until reset.
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idex_stall  = idex_stall;
  assign bus.exmem_stall = exmem_stall;
  assign bus.memwb_stall = memwb_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.halted      = halted_q;
  assign bus.err         = err_q;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline control block for the 16-bit five-stage core. It generates the stall (register-hold) and flush (NOP/bubble insertion) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, taken-branch redirects and instruction- and data-memory busy conditions. It also sequences the HALT drain with a small state machine. Its idex_stall and idex_flush outputs drive the ID/EX register's Stall_disable and Flush inputs directly.

## Interface

- MEM_TIMEOUT, 64: consecutive dmem_stall cycles that raise err; legal range 2..255.
- DRAIN_CYCLES, 3: cycles to drain a HALT from ID through WB; legal range 1..7.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs  in  3  source register 1 of the instruction in ID
- ifid_rt  in  3  source register 2 of the instruction in ID
- ifid_rs_used  in  1  the ID instruction reads rs
- ifid_rt_used  in  1  the ID instruction reads rt
- ifid_halt  in  1  the ID instruction is HALT (CreateDump)
- idex_rd  in  3  destination register of the instruction in EX
- idex_regwrite  in  1  the EX instruction writes a register
- idex_memread  in  1  the EX instruction is a load
- ex_take_branch  in  1  taken branch or jump resolved in EX
- imem_stall  in  1  instruction memory busy; fetched word invalid
- dmem_stall  in  1  data memory busy; the MEM stage must hold
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_stall  out  1  hold ID/EX
- exmem_stall  out  1  hold EX/MEM
- memwb_stall  out  1  hold MEM/WB
- ifid_flush  out  1  load a bubble into IF/ID
- idex_flush  out  1  load a bubble (NOP 0x0800, controls cleared) into ID/EX
- halted  out  1  pipeline drained after HALT; registered
- err  out  1  sticky data-memory timeout flag; registered

## Operation

- State register: RUN, DRAIN, HALTED. Reset places the block in RUN.
- All stall and flush outputs are combinational from the current state and current inputs. When several conditions apply, the first matching rule in this priority order determines the outputs:
  1. HALTED: all five stalls are 1; both flushes are 0.
  2. dmem_stall=1 (any state): all five stalls are 1; both flushes are 0. A branch held in ID/EX is re-evaluated after the release.
  3. ex_take_branch=1: ifid_flush=1 and idex_flush=1; all stalls are 0. The PC loads the branch target.
  4. DRAIN: pc_stall=1 and ifid_flush=1; all other outputs are 0.
  5. Load-use: idex_memread & idex_regwrite & ((ifid_rs_used & ifid_rs==idex_rd) | (ifid_rt_used & ifid_rt==idex_rd)). Outputs are pc_stall=1, ifid_stall=1, idex_flush=1; everything else is 0. This gives exactly one bubble, because the load advances on the next cycle.
  6. imem_stall=1: pc_stall=1 and ifid_flush=1; everything else is 0.
  7. Otherwise all outputs are 0.
- Load-use and imem_stall together: the load-use rule applies, and IF/ID holds the valid ID instruction.
- RUN to DRAIN: at a clock edge where the state is RUN, ifid_halt=1, dmem_stall=0, ex_take_branch=0 and the load-use condition is false. The drain counter loads DRAIN_CYCLES-1.
- In DRAIN:
  - The counter decrements on each edge where dmem_stall=0 and holds otherwise.
  - On an edge where dmem_stall=0 and the counter is 0, the state moves to HALTED and halted is set.
  - A HALT that is flushed by a branch never enters DRAIN.
- HALTED exits only through reset.
- Timeout counter (8-bit, saturating):
  - Increments on each edge with dmem_stall=1; clears on each edge with dmem_stall=0.
  - err is set on the edge where the count reaches MEM_TIMEOUT-1 with dmem_stall still 1. err stays set until reset.
  - err does not change the stall behaviour.

## Timing

- The stall/flush outputs have zero latency: they respond in the same cycle as their inputs.
- halted and err are registered and update one edge after their condition.
- Reset:
  - While rst_n=0, all stall and flush outputs are 0, halted=0 and err=0.
  - The state, drain counter and timeout counter clear immediately (asynchronously).
  - Reset asserted mid-drain or mid-stall abandons the sequence with no residue.
- A single load-use hazard costs exactly 1 cycle.
- A taken branch inserts 2 bubbles (IF/ID and ID/EX).
- HALT: halted rises DRAIN_CYCLES edges after the entry edge, plus one edge for every dmem_stall cycle seen during DRAIN.

## Test plan

- Load-use: EX holds a load with rd=3 and ID has rs=3 with rs_used=1. Required: pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, then all outputs 0.
- Branch during load-use: ex_take_branch=1 while the load-use condition is also true. Required: ifid_flush=idex_flush=1 and all stalls 0.
- dmem_stall held for 5 cycles while ex_take_branch=1. Required: all stalls=1 and flushes=0 for 5 cycles; on the 6th cycle ifid_flush=idex_flush=1.
- HALT drain with DRAIN_CYCLES=3 and one dmem_stall cycle inside DRAIN. Required: halted rises 4 edges after DRAIN entry; afterwards all stalls=1 permanently.
- Timeout with MEM_TIMEOUT=4: dmem_stall held for 4 cycles. Required: err=1 after the 4th edge and still 1 after dmem_stall drops.
- Assert rst_n=0 while in DRAIN with err=1. Required: halted=0, err=0 and all outputs 0 immediately. After release with idle inputs, all outputs stay 0.
